demux1x4_4bits_seq: RTL and testbench
=====================================

Name: demux1x4_4bits_seq

Overview:
Sequenced 1-to-4 demultiplexer for 4-bit nibbles, the distributing counterpart of the 4x1 4-bit selectors used on the display/data path. It accepts one nibble per valid/ready handshake and writes it into one of four registered output channels. The channel comes from an external select (direct mode) or an internal wrap-around pointer (auto mode). Auto mode flags each completed 4-nibble frame, so a downstream 4x1 selector or display scanner always reads a coherent set.

Parameters:
P_DATA, 4, width of each nibble/channel
P_SEL, 2, select/pointer width; channel count fixed at 4 = 2**P_SEL

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = direct (channel = sel), 1 = auto (channel = internal ptr)
sel  input  2  target channel in direct mode; ignored in auto mode
din  input  4  nibble to distribute
din_valid  input  1  din is valid this cycle
din_ready  output  1  block can accept this cycle (combinational)
hold  input  1  stall; forces din_ready low
clear  input  1  synchronous clear of outputs, pointer and FSM
out0  output  4  channel 0 register
out1  output  4  channel 1 register
out2  output  4  channel 2 register
out3  output  4  channel 3 register
upd  output  4  one-hot pulse, bit N high one cycle after channel N is written
frame_done  output  1  one-cycle pulse, auto mode only, after 4th write of a frame
ptr  output  2  current auto-mode pointer (next channel to be written)

Behaviour:
- Reset (rst_n=0, async): out0..out3=0, upd=0, frame_done=0, ptr=0, FSM=S_IDLE. Asserting mid-frame discards the partial frame immediately.
- din_ready = ~hold & ~clear & (state != S_DONE). Accept = din_valid & din_ready at a rising edge.
- Latency: 1 cycle. On accept at edge k, the target outN holds din and upd[N]=1 from edge k until edge k+1. Channels not written keep their values. upd is 0 in cycles with no accept.
- Direct mode: target = sel. FSM stays S_IDLE. ptr is held. frame_done is never asserted.
- Auto mode FSM:
  - S_IDLE (ptr=0): accept writes out0, ptr<=1, goes to S_FILL.
  - S_FILL: accept writes out[ptr], ptr<=ptr+1. The write at ptr=3 wraps ptr to 0, goes to S_DONE and sets frame_done=1 for the following cycle, coincident with upd[3].
  - S_DONE: lasts exactly 1 cycle with din_ready=0 so the consumer can latch the frame, then returns to S_IDLE.
- mode change while in S_FILL or S_DONE: next edge forces ptr=0 and S_IDLE. Outputs keep their values; the partial frame is abandoned and frame_done is not asserted. No write occurs on that edge even if din_valid=1.
- clear=1 (synchronous, highest priority after reset): at the next edge out0..3=0, ptr=0, S_IDLE, upd=0, frame_done=0. No write occurs (din_ready is already low).
- hold=1: no accept. State, ptr and outputs are frozen. S_DONE still expires after its one cycle.
- Back-to-back accepts are allowed every cycle except during S_DONE. A full auto frame therefore takes at least 5 cycles per 4 nibbles.
- All outputs except din_ready are registered.

Decomposition:
- Shared include/package: P_DATA and P_SEL widths, FSM state encodings S_IDLE=2'd0, S_FILL=2'd1, S_DONE=2'd2, and the MODE_DIRECT/MODE_AUTO constants.
- No sub-module required. The 2-bit wrap pointer stays inline. Channel registers are a 4-way enable decode from the target index.

Test Plan:
1. Reset: drive rst_n=0 asynchronously between edges -> all outputs 0 immediately, din_ready=1 after release with hold=0.
2. Direct mode: sel=2, din=0x9, valid 1 cycle -> out2=0x9 and upd=4'b0100 for one cycle. Other channels stay 0, frame_done stays 0.
3. Auto frame: mode=1, stream 0xA,0xB,0xC,0xD on consecutive cycles -> out0..3=A,B,C,D. upd walks 0001..1000. frame_done=1 with upd[3]. din_ready=0 for exactly the next cycle. ptr returns to 0.
4. Hold stall: during auto stream assert hold for 3 cycles after 0xA -> din_ready=0, ptr stays 1, nothing written. Resuming completes the frame with correct ordering.
5. Clear mid-frame: after 0x1,0x2, assert clear with din_valid=1, din=0xF -> no write, all outputs 0, ptr=0. Next 4 nibbles form a fresh frame.
6. Mode switch and async reset mid-frame: after 2 auto writes switch mode=0 -> ptr=0, no frame_done, out0/out1 retained. Separately, pulse rst_n low after 3 writes -> immediate zeroing, and the next frame starts at out0.

Source files
------------

// File: rtl/demux1x4_4bits_seq_pkg.sv
// Shared widths, FSM encodings and mode constants for the sequenced 1-to-4 nibble demultiplexer.
package demux1x4_4bits_seq_pkg;

    localparam int P_DATA = 4;
    localparam int P_SEL  = 2;
    localparam int N_CH   = 2 ** P_SEL;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    localparam logic [P_SEL-1:0] PTR_LAST = P_SEL'(N_CH - 1);

    function automatic logic [N_CH-1:0] ch_onehot(input logic [P_SEL-1:0] idx);
        ch_onehot      = '0;
        ch_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/demux1x4_4bits_seq.sv
// Sequenced 1-to-4 nibble demultiplexer: direct (sel) or auto (wrapping pointer) channel
// selection, registered channels, per-channel update pulses and an auto-mode frame flag.
module demux1x4_4bits_seq
    import demux1x4_4bits_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [P_SEL-1:0]  sel,
    input  logic [P_DATA-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              hold,
    input  logic              clear,
    output logic [P_DATA-1:0] out0,
    output logic [P_DATA-1:0] out1,
    output logic [P_DATA-1:0] out2,
    output logic [P_DATA-1:0] out3,
    output logic [N_CH-1:0]   upd,
    output logic              frame_done,
    output logic [P_SEL-1:0]  ptr,
    output logic [1:0]        state_dbg
);

    // Handshake: a nibble is taken on a rising edge where din_valid and din_ready are both high;
    // din_ready never depends on din_valid, and the source may hold din_valid while din_ready is low.

    logic [1:0]        state_q, state_d;
    logic [P_SEL-1:0]  ptr_q, ptr_d;
    logic [N_CH-1:0]   upd_q, upd_d;
    logic              frame_done_q, frame_done_d;
    logic [P_DATA-1:0] out_q [N_CH];
    logic [P_DATA-1:0] out_d [N_CH];

    logic              abort;
    logic              accept;
    logic [P_SEL-1:0]  target;
    logic [N_CH-1:0]   wr_en;

    // Leaving auto mode mid-frame abandons the frame; ready is dropped so no nibble is lost.
    assign abort     = (state_q != S_IDLE) && (mode == MODE_DIRECT);
    assign din_ready = ~hold & ~clear & (state_q != S_DONE) & ~abort;
    assign accept    = din_valid & din_ready;
    assign target    = (mode == MODE_AUTO) ? ptr_q : sel;
    assign wr_en     = accept ? ch_onehot(target) : '0;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        upd_d        = '0;
        frame_done_d = 1'b0;
        if (clear || abort) begin
            state_d = S_IDLE;
            ptr_d   = '0;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (accept) begin
            upd_d = wr_en;
            if (mode == MODE_AUTO) begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d      = S_DONE;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = S_FILL;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            out_d[i] = out_q[i];
            if (clear) begin
                out_d[i] = '0;
            end else if (wr_en[i]) begin
                out_d[i] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            upd_q        <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            upd_q        <= upd_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < N_CH; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    assign out0       = out_q[0];
    assign out1       = out_q[1];
    assign out2       = out_q[2];
    assign out3       = out_q[3];
    assign upd        = upd_q;
    assign frame_done = frame_done_q;
    assign ptr        = ptr_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_demux1x4_4bits_seq.sv
// Self-checking bench for demux1x4_4bits_seq: directed scenarios then random traffic,
// compared every cycle against a frame-counting reference model.
module tb_demux1x4_4bits_seq;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       hold;
    logic       clear;
    logic [3:0] out0, out1, out2, out3;
    logic [3:0] upd;
    logic       frame_done;
    logic [1:0] ptr;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: nibbles written in the current auto frame, and whether the
    // one-cycle post-frame gap is pending.
    logic [3:0] m_out [4];
    logic [3:0] m_upd;
    logic       m_fd;
    int         m_fill;
    bit         m_gap;
    logic [5:0] exp_q [$];

    demux1x4_4bits_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .sel        (sel),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .hold       (hold),
        .clear      (clear),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .upd        (upd),
        .frame_done (frame_done),
        .ptr        (ptr),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
        m_upd  = 4'h0;
        m_fd   = 1'b0;
        m_fill = 0;
        m_gap  = 1'b0;
        exp_q.delete();
    endtask

    function automatic bit model_ready();
        bit mid_frame_switch;
        mid_frame_switch = (mode == 1'b0) && (m_fill > 0 || m_gap);
        return !hold && !clear && !m_gap && !mid_frame_switch;
    endfunction

    task automatic model_advance(input bit rdy);
        int ch;
        m_upd = 4'h0;
        m_fd  = 1'b0;
        if (clear) begin
            for (int i = 0; i < 4; i++) m_out[i] = 4'h0;
            m_fill = 0;
            m_gap  = 1'b0;
        end else if (mode == 1'b0 && (m_fill > 0 || m_gap)) begin
            m_fill = 0;
            m_gap  = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (din_valid && rdy) begin
            ch        = mode ? m_fill : int'(sel);
            m_out[ch] = din;
            m_upd     = 4'h1 << ch;
            exp_q.push_back({2'(ch), din});
            if (mode) begin
                m_fill++;
                if (m_fill == 4) begin
                    m_fill = 0;
                    m_gap  = 1'b1;
                    m_fd   = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [5:0] wr;
        logic [3:0] outs [4];
        outs[0] = out0; outs[1] = out1; outs[2] = out2; outs[3] = out3;
        check_eq("out0", 32'(out0), 32'(m_out[0]));
        check_eq("out1", 32'(out1), 32'(m_out[1]));
        check_eq("out2", 32'(out2), 32'(m_out[2]));
        check_eq("out3", 32'(out3), 32'(m_out[3]));
        check_eq("upd", 32'(upd), 32'(m_upd));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("ptr", 32'(ptr), 32'(m_fill));
        if (exp_q.size() > 0) begin
            wr = exp_q.pop_front();
            check_eq("wr_data", 32'(outs[wr[5:4]]), 32'(wr[3:0]));
        end
    endtask

    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] d,
                        input logic v, input logic h, input logic c);
        bit rdy;
        @(negedge clk);
        mode = m; sel = s; din = d; din_valid = v; hold = h; clear = c;
        #1;
        rdy = model_ready();
        check_eq("din_ready", 32'(din_ready), 32'(rdy));
        model_advance(rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        @(negedge clk);
        din_valid = 1'b0; hold = 1'b0; clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; din = 4'h0;
        din_valid = 1'b0; hold = 1'b0; clear = 1'b0;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("ready_after_reset", 32'(din_ready), 32'(1));

        // Direct write to channel 2
        step(1'b0, 2'd2, 4'h9, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Full auto frame, then valid held during the gap cycle
        step(1'b1, 2'd3, 4'hA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd3, 4'hB, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd3, 4'hC, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd3, 4'hD, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd3, 4'h5, 1'b1, 1'b0, 1'b0);

        // Hold for 3 cycles after the first nibble
        step(1'b1, 2'd0, 4'hA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'h7, 1'b1, 1'b1, 1'b0);
        step(1'b1, 2'd0, 4'hB, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'hC, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'hD, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Clear mid-frame with valid data present, then a fresh frame
        step(1'b1, 2'd0, 4'h1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'h2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'hF, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 4'(i + 3), 1'b1, 1'b0, 1'b0);

        // Mode switch after two auto writes, with valid high on the switch edge
        step(1'b1, 2'd0, 4'h6, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'h8, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd3, 4'hE, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd3, 4'hE, 1'b1, 1'b0, 1'b0);

        // Async reset after three auto writes, then a new frame from channel 0
        step(1'b1, 2'd0, 4'h1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'h2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 4'h3, 1'b1, 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 4'(12 - i), 1'b1, 1'b0, 1'b0);

        // Random traffic; mode changes are rare so full frames still occur
        begin
            logic r_mode;
            r_mode = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 39) == 0) r_mode = ~r_mode;
                if ($urandom_range(0, 299) == 0) begin
                    async_reset();
                end else begin
                    step(r_mode,
                         2'($urandom_range(0, 3)),
                         4'($urandom_range(0, 15)),
                         ($urandom_range(0, 3) != 0),
                         ($urandom_range(0, 7) == 0),
                         ($urandom_range(0, 39) == 0));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
